nibble_serial_add_seq: RTL and testbench

//  Sequencer that adds two WIDTH-bit operands using one external 4-bit

---
 rtl/nibble_serial_add_seq.sv | 119 +++++++++++
 tb/tb_nibble_serial_add_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_seq.sv
// Serial WIDTH-bit adder sequencer driving an external 4-bit combinational adder slice,
// LSB nibble first. Define OVERFLOW_FLAG_EN to add the signed-overflow output ovf.
module nibble_serial_add_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic [3:0]       add_a,
   output logic [3:0]       add_b,
   output logic             add_cin,
   input  logic [3:0]       add_s,
   input  logic             add_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef OVERFLOW_FLAG_EN
   output logic             ovf,
`endif
   output logic [1:0]       dbg_state
);

   localparam int NSLICE = WIDTH / 4;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_shift;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             run;
`ifdef OVERFLOW_FLAG_EN
   logic             a_msb;
   logic             b_msb;
`endif

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // in_ready comes from the registered state alone; out_valid with sum/cout/ovf holds
   // stable until out_ready is seen.
   assign run       = (state == RUN);
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign dbg_state = state;

   assign add_a   = run ? a_sh[3:0] : 4'd0;
   assign add_b   = run ? b_sh[3:0] : 4'd0;
   assign add_cin = run ? carry : 1'b0;

   assign sum  = out_valid ? res : '0;
   assign cout = out_valid ? carry : 1'b0;

`ifdef OVERFLOW_FLAG_EN
   assign ovf = out_valid && (a_msb == b_msb) && (res[WIDTH-1] != a_msb);
`endif

   // Each new slice sum enters at the top, so after NSLICE steps nibble 0 sits at the bottom.
   generate
      if (WIDTH > 4) begin : g_wide
         assign res_shift = {add_s, res[WIDTH-1:4]};
      end else begin : g_narrow
         assign res_shift = add_s;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
`ifdef OVERFLOW_FLAG_EN
         a_msb <= 1'b0;
         b_msb <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= in_a;
                  b_sh  <= in_b;
                  carry <= in_cin;
                  cnt   <= '0;
`ifdef OVERFLOW_FLAG_EN
                  a_msb <= in_a[WIDTH-1];
                  b_msb <= in_b[WIDTH-1];
`endif
                  state <= RUN;
               end
            end
            RUN: begin
               res   <= res_shift;
               carry <= add_cout;
               a_sh  <= a_sh >> 4;
               b_sh  <= b_sh >> 4;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(NSLICE - 1)) state <= DONE;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Directed vector bench for nibble_serial_add_seq (WIDTH=16) with a behavioural 4-bit adder slice.
module tb_nibble_serial_add_seq;

   localparam int W      = 16;
   localparam int NSLICE = W / 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_cin = 1'b0;
   logic [3:0]   add_a;
   logic [3:0]   add_b;
   logic         add_cin;
   logic [3:0]   add_s;
   logic         add_cout;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
`ifdef OVERFLOW_FLAG_EN
   logic         ovf;
`endif
   logic [1:0]   dbg_state;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs[10];
   int   n_cmp  = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

   nibble_serial_add_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_s     (add_s),
      .add_cout  (add_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
`ifdef OVERFLOW_FLAG_EN
      .ovf       (ovf),
`endif
      .dbg_state (dbg_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Applies one operand set; hold>0 keeps out_ready low (with a pending in_valid) that many extra cycles in DONE.
   task automatic run_op(input vec_t v, input int idx, input int hold);
      logic       c;
      logic [4:0] t;
      @(negedge clk);
      check($sformatf("v%0d in_ready_idle", idx), 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_a     = v.a;
      in_b     = v.b;
      in_cin   = v.cin;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_cin   = 1'($urandom_range(0, 1));
      c = v.cin;
      for (int k = 0; k < NSLICE; k++) begin
         @(negedge clk);
         check($sformatf("v%0d s%0d out_valid", idx, k), 32'(out_valid), 32'd0);
         check($sformatf("v%0d s%0d add_a", idx, k), 32'(add_a), 32'(v.a[4*k +: 4]));
         check($sformatf("v%0d s%0d add_b", idx, k), 32'(add_b), 32'(v.b[4*k +: 4]));
         check($sformatf("v%0d s%0d add_cin", idx, k), 32'(add_cin), 32'(c));
         t = {1'b0, v.a[4*k +: 4]} + {1'b0, v.b[4*k +: 4]} + {4'd0, c};
         c = t[4];
      end
      @(negedge clk);
      check($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'd1);
      check($sformatf("v%0d sum", idx), 32'(sum), 32'(v.exp_sum));
      check($sformatf("v%0d cout", idx), 32'(cout), 32'(v.exp_cout));
      check($sformatf("v%0d add_idle", idx), 32'({add_a, add_b, add_cin}), 32'd0);
`ifdef OVERFLOW_FLAG_EN
      check($sformatf("v%0d ovf", idx), 32'(ovf), 32'(v.exp_ovf));
`endif
      if (hold > 0) begin
         in_valid = 1'b1;
         in_a     = W'($urandom);
         in_b     = W'($urandom);
         repeat (hold) begin
            @(negedge clk);
            check($sformatf("v%0d hold out_valid", idx), 32'(out_valid), 32'd1);
            check($sformatf("v%0d hold sum", idx), 32'(sum), 32'(v.exp_sum));
            check($sformatf("v%0d hold cout", idx), 32'(cout), 32'(v.exp_cout));
            check($sformatf("v%0d hold in_ready", idx), 32'(in_ready), 32'd0);
            check($sformatf("v%0d hold state", idx), 32'(dbg_state), 32'(S_DONE));
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d back_idle", idx), 32'(dbg_state), 32'(S_IDLE));
      check($sformatf("v%0d out_valid_low", idx), 32'(out_valid), 32'd0);
      in_valid = 1'b0;
   endtask

   initial begin
      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[4] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
      vecs[6] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0};
      vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[8] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[9] = '{16'h6000, 16'h2000, 1'b1, 16'h8001, 1'b0, 1'b1};

      repeat (2) @(negedge clk);
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst sum", 32'(sum), 32'd0);
      check("rst cout", 32'(cout), 32'd0);
      check("rst add", 32'({add_a, add_b, add_cin}), 32'd0);
      check("rst state", 32'(dbg_state), 32'(S_IDLE));
`ifdef OVERFLOW_FLAG_EN
      check("rst ovf", 32'(ovf), 32'd0);
`endif
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) run_op(vecs[i], i, 0);

      // Result held in DONE while a new operand set waits.
      run_op(vecs[1], 10, 3);

      // Reset pulse in the middle of slice 2.
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = 16'h1234;
      in_b     = 16'h4321;
      in_cin   = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid state_run", 32'(dbg_state), 32'(S_RUN));
      rst_n = 1'b0;
      #1;
      check("mid rst out_valid", 32'(out_valid), 32'd0);
      check("mid rst sum", 32'(sum), 32'd0);
      check("mid rst add", 32'({add_a, add_b, add_cin}), 32'd0);
      check("mid rst in_ready", 32'(in_ready), 32'd1);
      check("mid rst state", 32'(dbg_state), 32'(S_IDLE));
      #2;
      rst_n = 1'b1;
      run_op(vecs[0], 11, 0);
      run_op(vecs[4], 12, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
      $finish;
   end

endmodule
